// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from an upstream FIFO and sends 8N1 frames.
// Define FIFO_UART_TX_PARITY_EN to append an even-parity bit (8E1 framing).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_read_data_i,
  output logic       fifo_r_enable_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;
  logic          tx_done_q;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  assign fifo_r_enable_o = (state_q == IDLE) && !fifo_empty_i && !reset_i;
  assign tx_o            = tx_q;
  assign busy_o          = busy_q;
  assign tx_done_o       = tx_done_q;

  // tx_q is loaded on the edge that enters each state, so it lines up with that state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      if (state_q == IDLE || state_q == LOAD) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          if (!fifo_empty_i) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          shift_q   <= fifo_read_data_i;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_q  <= ^fifo_read_data_i;
`endif
          bit_idx_q <= '0;
          tx_q      <= 1'b0;
          state_q   <= START;
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt_q == CNT_PRE) tx_done_q <= 1'b1;
          if (bit_end) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a queue-based FIFO model feeds the DUT and
// a line monitor compares every tx sample against the frame built from each byte.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_read_data = 8'h00;
  logic       r_en, tx, busy, tx_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock_i          (clk),
    .reset_i          (reset_i),
    .fifo_empty_i     (fifo_empty),
    .fifo_read_data_i (fifo_read_data),
    .fifo_r_enable_o  (r_en),
    .tx_o             (tx),
    .busy_o           (busy),
    .tx_done_o        (tx_done)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int rd_count = 0;
  int frames_done = 0;
  int busy_samples = 0;
  int pushed = 0;
  int pos = 0;
  bit in_frame = 1'b0;
  bit ren_s = 1'b0;
  bit prev_ren = 1'b0;
  bit prev_rst = 1'b0;
  bit gap_check = 1'b0;
  int gap = 0;
  logic [7:0] cur = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level for frame bit slot idx: start, 8 data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == NB - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
    pushed++;
  endtask

  task automatic wait_frames(input int n);
    int c;
    c = 0;
    while (frames_done < n && c < 2000) begin
      @(posedge clk);
      c++;
    end
    chk("frame_timeout", frames_done >= n, 1);
  endtask

  // Upstream FIFO: data appears the cycle after a sampled read strobe.
  initial begin
    forever begin
      @(negedge clk);
      ren_s = r_en;
      @(posedge clk); #1;
      if (ren_s && fifo_q.size() > 0) fifo_read_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Line monitor / scoreboard checker.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_i) begin
        chk("ren_in_reset", r_en, 0);
        if (prev_rst) begin
          chk("rst_tx", tx, 1);
          chk("rst_busy", busy, 0);
          chk("rst_done", tx_done, 0);
        end
        in_frame  = 1'b0;
        gap_check = 1'b0;
        prev_ren  = 1'b0;
        prev_rst  = 1'b1;
      end else begin
        if (prev_rst) begin
          chk("post_rst_tx", tx, 1);
          chk("post_rst_busy", busy, 0);
        end
        if (r_en) begin
          rd_count++;
          chk("ren_only_idle", in_frame || busy || prev_ren, 0);
        end
        if (!in_frame && tx == 1'b0) begin
          if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
          else cur = exp_q.pop_front();
          if (gap_check) chk("frame_gap", gap, 2);
          in_frame  = 1'b1;
          pos       = 0;
          gap_check = 1'b0;
        end
        if (in_frame) begin
          chk("tx_bit", tx, exp_bit(cur, pos / CPB));
          chk("tx_done", tx_done, pos == NB * CPB - 1);
          chk("busy_frame", busy, 1);
          pos++;
          if (pos == NB * CPB) begin
            in_frame = 1'b0;
            frames_done++;
            gap_check = !fifo_empty;
            gap = 0;
          end
        end else begin
          chk("tx_idle", tx, 1);
          chk("done_idle", tx_done, 0);
          chk("busy_idle", busy, prev_ren);
          gap++;
        end
        if (busy) busy_samples++;
        prev_ren = r_en;
        prev_rst = 1'b0;
      end
    end
  end

  initial begin
    int b0;
    int c;
    int n;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("rel_tx", tx, 1);
    chk("rel_busy", busy, 0);
    chk("rel_done", tx_done, 0);
    chk("rel_ren", r_en, 0);

    repeat (100) @(posedge clk);
    #1 chk("idle_reads", rd_count, 0);

    b0 = busy_samples;
    push(8'hA5);
    wait_frames(1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_len", busy_samples - b0, NB * CPB + 1);
    chk("reads_a5", rd_count, 1);

    push(8'h07);
    wait_frames(2);

    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_frames(5);
    chk("reads_b2b", rd_count, 5);

    push(8'h55);
    push(8'h99);
    c = 0;
    while (c < 2000) begin
      @(posedge clk); #1;
      if (in_frame && (pos / CPB) == 4) break;
      c++;
    end
    chk("bit3_timeout", c < 2000, 1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    wait_frames(6);
    chk("reads_after_abort", rd_count, 7);

    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) push(8'($urandom));
      repeat ($urandom_range(0, 60)) @(posedge clk);
    end

    c = 0;
    while (c < 5000 && (exp_q.size() != 0 || fifo_q.size() != 0 || in_frame || busy)) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_timeout", c < 5000, 1);
    chk("final_reads", rd_count, pushed);
    chk("final_frames", frames_done, pushed - 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
- REQ-001: Parameter CLKS_PER_BIT, default 868, SHALL set clock cycles per serial bit; legal range 2..65535.
- REQ-002: clock  input  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-003: reset  input  1  SHALL be a synchronous, active-high reset.
- REQ-004: fifo_empty  input  1  SHALL be the upstream FIFO empty flag.
- REQ-005: fifo_read_data  input  8  SHALL be the upstream FIFO read data, valid the cycle after a read strobe.
- REQ-006: fifo_r_enable  output  1  SHALL be the read strobe to the upstream FIFO.
- REQ-007: tx  output  1  SHALL be the UART serial line, idle high.
- REQ-008: busy  output  1  SHALL be high while a frame is being fetched or sent.
- REQ-009: tx_done  output  1  SHALL be a one-cycle pulse marking frame completion.

Function
- REQ-010: FSM states SHALL be IDLE, LOAD, START, DATA, PARITY (macro only), STOP.
- REQ-011: fifo_r_enable SHALL be combinational: high only when state is IDLE, fifo_empty is 0 and reset is 0.
- REQ-012: IDLE with fifo_empty=0 SHALL transition to LOAD on the next edge; IDLE with fifo_empty=1 SHALL remain in IDLE.
- REQ-013: LOAD SHALL last exactly one cycle, capture fifo_read_data into an 8-bit shift register, then enter START.
- REQ-014: START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles.
- REQ-015: DATA SHALL send 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles.
- REQ-016: STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
- REQ-017: tx_done SHALL be high during the last cycle of STOP only.
- REQ-018: busy SHALL be 0 in IDLE and 1 in every other state.
- REQ-019: tx SHALL be registered and SHALL be 1 in IDLE and LOAD.
- REQ-020: The bit-timing counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap to 0 at CLKS_PER_BIT-1; the bit index SHALL be 3 bits wide.
- REQ-021: With the FIFO non-empty, consecutive frames SHALL be separated by exactly 2 idle-high cycles (IDLE + LOAD).
- REQ-022: Exactly one FIFO read SHALL occur per frame; no read SHALL occur outside IDLE.
- REQ-023: fifo_empty changes after LOAD SHALL NOT affect the frame in progress.

Reset
- REQ-024: On reset, next edge SHALL set state=IDLE, tx=1, busy=0, tx_done=0, counters and shift register 0.
- REQ-025: Reset mid-frame SHALL abort the frame, discard the byte (no re-read), and force tx=1 on the next edge.
- REQ-026: While reset is high, fifo_r_enable SHALL be 0 regardless of fifo_empty.

Configuration
- REQ-027: Macro FIFO_UART_TX_PARITY_EN defined SHALL insert a PARITY state between DATA and STOP, sending the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11 bits.
- REQ-028: Macro FIFO_UART_TX_PARITY_EN undefined SHALL omit the PARITY state and its logic; frame = 10 bits (8N1).

Verification (CLKS_PER_BIT=4)
- REQ-029: Reset held 3 cycles -> tx=1, busy=0, tx_done=0, fifo_r_enable=0 throughout and after release with fifo_empty=1.
- REQ-030: fifo_empty=1 for 100 cycles after reset -> no fifo_r_enable pulse, tx constant 1, busy 0.
- REQ-031: One byte 0xA5 -> single 1-cycle fifo_r_enable; tx sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles); tx_done pulses on cycle 40; busy high 41 cycles.
- REQ-032: FIFO holding 0x00,0xFF,0x3C -> three read strobes, frames separated by exactly 2 tx=1 cycles, bytes reproduced LSB first.
- REQ-033: Reset asserted during bit 3 of 0x55 -> tx=1 and busy=0 on next edge; next frame after release carries the next FIFO byte, not 0x55.
- REQ-034: FIFO_UART_TX_PARITY_EN defined, bytes 0xA5 then 0x07 -> parity bits 0 then 1; frame 44 cycles each.
